// File: rtl/channel_mixer_seq.sv
// channel_mixer_seq: time-multiplexed audio mixer.
// Mixes NUM_CH signed voices into one saturated signed sample using a
// single multiply-accumulate per clock. Inputs are snapshotted on
// acceptance, so the live inputs may change while a mix is running.
module channel_mixer_seq #(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 18,
    parameter int GAIN_W = 8,
    parameter int SHIFT  = 2,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     calcul_en,
    input  logic [NUM_CH*IN_W-1:0]   ch_sound,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [NUM_CH-1:0]        ch_mute,
    output logic [OUT_W-1:0]         data_out,
    output logic                     valid_out,
    output logic                     clip,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int PROD_W = IN_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
    localparam int NORM   = GAIN_W - 1 + SHIFT;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    // Saturation bounds expressed at accumulator width for a signed compare.
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic [1:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_CH*IN_W-1:0]    snd_q, snd_d;
    logic [NUM_CH*GAIN_W-1:0]  gain_q, gain_d;
    logic [NUM_CH-1:0]         mute_q, mute_d;
    logic [OUT_W-1:0]          data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      clip_q, clip_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    logic signed [IN_W-1:0]    smp_s;
    logic signed [GAIN_W:0]    gain_ext_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   scaled_s;

    // Product of the channel currently at the bottom of the snapshot shift registers.
    always_comb begin
        smp_s      = snd_q[IN_W-1:0];
        gain_ext_s = {1'b0, gain_q[GAIN_W-1:0]};
        if (mute_q[0]) begin
            prod_s = '0;
        end else begin
            prod_s = PROD_W'(smp_s) * PROD_W'(gain_ext_s);
        end
        scaled_s = acc_q >>> NORM;
    end

    // Sequencer: accept, accumulate one channel per cycle, then scale and saturate.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        snd_d     = snd_q;
        gain_d    = gain_q;
        mute_d    = mute_q;
        data_d    = data_q;
        clip_d    = clip_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (calcul_en) begin
                    snd_d   = ch_sound;
                    gain_d  = ch_gain;
                    mute_d  = ch_mute;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                overrun_d = calcul_en;
                acc_d     = acc_q + ACC_W'(prod_s);
                idx_d     = idx_q + IDX_W'(1);
                snd_d     = snd_q >> IN_W;
                gain_d    = gain_q >> GAIN_W;
                mute_d    = mute_q >> 1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                overrun_d = calcul_en;
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
                if (scaled_s > OUT_MAX) begin
                    data_d = {1'b0, {(OUT_W-1){1'b1}}};
                    clip_d = 1'b1;
                end else if (scaled_s < OUT_MIN) begin
                    data_d = {1'b1, {(OUT_W-1){1'b0}}};
                    clip_d = 1'b1;
                end else begin
                    data_d = scaled_s[OUT_W-1:0];
                    clip_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any mix in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            snd_q     <= '0;
            gain_q    <= '0;
            mute_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            snd_q     <= snd_d;
            gain_q    <= gain_d;
            mute_q    <= mute_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign clip      = clip_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_channel_mixer_seq.sv
// Self-checking bench for channel_mixer_seq with directed and random mixes
// compared against an arithmetic reference model.
module tb_channel_mixer_seq;

    localparam int NUM_CH = 16;
    localparam int IN_W   = 18;
    localparam int GAIN_W = 8;
    localparam int SHIFT  = 2;
    localparam int OUT_W  = 16;
    localparam int SW     = NUM_CH * IN_W;
    localparam int GW     = NUM_CH * GAIN_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              calcul_en;
    logic [SW-1:0]     ch_sound;
    logic [GW-1:0]     ch_gain;
    logic [NUM_CH-1:0] ch_mute;
    logic [OUT_W-1:0]  data_out;
    logic              valid_out;
    logic              clip;
    logic              busy;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_ovr    = 0;

    channel_mixer_seq #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .calcul_en(calcul_en), .ch_sound(ch_sound),
        .ch_gain(ch_gain), .ch_mute(ch_mute), .data_out(data_out),
        .valid_out(valid_out), .clip(clip), .busy(busy), .overrun(overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (valid_out) n_valid++;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: full-precision weighted sum, floor division, clamp.
    task automatic model(input logic [SW-1:0] snd, input logic [GW-1:0] gn,
                         input logic [NUM_CH-1:0] mt,
                         output logic [OUT_W-1:0] d, output logic c);
        longint sum;
        longint s;
        longint lim;
        sum = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!mt[i])
                sum += longint'($signed(snd[i*IN_W +: IN_W])) * longint'(gn[i*GAIN_W +: GAIN_W]);
        end
        s   = sum >>> (GAIN_W - 1 + SHIFT);
        lim = longint'(1) <<< (OUT_W - 1);
        if (s > lim - 1) begin
            s = lim - 1;
            c = 1'b1;
        end else if (s < -lim) begin
            s = -lim;
            c = 1'b1;
        end else begin
            c = 1'b0;
        end
        d = s[OUT_W-1:0];
    endtask

    task automatic scramble();
        ch_sound = {SW{1'b0}};
        for (int i = 0; i < NUM_CH; i++) ch_sound[i*IN_W +: IN_W] = IN_W'($urandom);
        for (int i = 0; i < NUM_CH; i++) ch_gain[i*GAIN_W +: GAIN_W] = GAIN_W'($urandom);
        ch_mute = NUM_CH'($urandom);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid_out && cyc < 100) begin
            scramble();
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_mix(input string tag, input logic [SW-1:0] snd,
                           input logic [GW-1:0] gn, input logic [NUM_CH-1:0] mt);
        logic [OUT_W-1:0] ed;
        logic             ec;
        int               cyc;
        model(snd, gn, mt, ed, ec);
        @(negedge clk);
        ch_sound  = snd;
        ch_gain   = gn;
        ch_mute   = mt;
        calcul_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calcul_en = 1'b0;
        chk({tag, "_busy"}, longint'(busy), 1);
        wait_valid(cyc);
        chk({tag, "_latency"}, cyc, NUM_CH + 1);
        chk({tag, "_valid"}, longint'(valid_out), 1);
        chk({tag, "_busy_low"}, longint'(busy), 0);
        chk({tag, "_data"}, longint'(data_out), longint'(ed));
        chk({tag, "_clip"}, longint'(clip), longint'(ec));
        @(negedge clk);
        chk({tag, "_pulse"}, longint'(valid_out), 0);
        chk({tag, "_hold"}, longint'(data_out), longint'(ed));
    endtask

    logic [SW-1:0]     snd_v;
    logic [GW-1:0]     gn_v;
    logic [NUM_CH-1:0] mt_v;
    logic [SW-1:0]     basic_snd;
    logic [GW-1:0]     unity_gn;
    int                v0;
    int                o0;
    int                cyc;
    int                tmp;

    initial begin
        rst       = 1'b1;
        calcul_en = 1'b0;
        ch_sound  = '0;
        ch_gain   = '0;
        ch_mute   = '0;
        basic_snd = '0;
        basic_snd[0*IN_W +: IN_W] = 18'd128;
        basic_snd[1*IN_W +: IN_W] = 18'd64;
        unity_gn  = {NUM_CH{8'd128}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_data", longint'(data_out), 0);
        chk("reset_valid", longint'(valid_out), 0);
        chk("reset_clip", longint'(clip), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_overrun", longint'(overrun), 0);
        rst = 1'b0;

        run_mix("basic", basic_snd, unity_gn, '0);
        chk("basic_const", longint'(data_out), 48);
        run_mix("mute", basic_snd, unity_gn, 16'h0002);
        chk("mute_const", longint'(data_out), 32);
        run_mix("sat_neg", {NUM_CH{18'h20000}}, {NUM_CH{8'd255}}, '0);
        chk("sat_neg_const", longint'(data_out), 32768);
        run_mix("sat_pos", {NUM_CH{18'h1FFFF}}, {NUM_CH{8'd255}}, '0);
        chk("sat_pos_const", longint'(data_out), 32767);
        chk("sat_pos_clip", longint'(clip), 1);

        // Reset in the middle of a mix.
        snd_v = '0;
        snd_v[0 +: IN_W] = 18'd128;
        @(negedge clk);
        ch_sound = snd_v; ch_gain = unity_gn; ch_mute = '0; calcul_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calcul_en = 1'b0;
        repeat (7) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", longint'(busy), 0);
        chk("rst_mid_data", longint'(data_out), 0);
        chk("rst_mid_valid", longint'(valid_out), 0);
        chk("rst_mid_clip", longint'(clip), 0);
        v0 = n_valid;
        repeat (25) @(posedge clk);
        chk("rst_mid_no_valid", n_valid - v0, 0);
        run_mix("post_rst", basic_snd, unity_gn, '0);

        snd_v = '0;
        snd_v[0 +: IN_W] = 18'h3FFFF;
        run_mix("floor", snd_v, unity_gn, '0);
        chk("floor_const", longint'(data_out), 65535);

        // Overrun: second request at E5, third right after valid_out.
        @(negedge clk);
        v0 = n_valid;
        o0 = n_ovr;
        ch_sound = basic_snd; ch_gain = unity_gn; ch_mute = '0; calcul_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calcul_en = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        calcul_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calcul_en = 1'b0;
        chk("ovr_pulse", longint'(overrun), 1);
        @(posedge clk);
        @(negedge clk);
        chk("ovr_single", longint'(overrun), 0);
        cyc = 0;
        while (!valid_out && cyc < 100) begin @(posedge clk); @(negedge clk); cyc++; end
        chk("ovr_valid", longint'(valid_out), 1);
        chk("ovr_data", longint'(data_out), 48);
        calcul_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        calcul_en = 1'b0;
        chk("ovr_third_no_ovr", longint'(overrun), 0);
        chk("ovr_third_busy", longint'(busy), 1);
        cyc = 0;
        while (!valid_out && cyc < 100) begin @(posedge clk); @(negedge clk); cyc++; end
        chk("ovr_third_latency", cyc, NUM_CH + 1);
        @(posedge clk);
        chk("ovr_valid_count", n_valid - v0, 2);
        chk("ovr_ovr_count", n_ovr - o0, 1);

        // Random mixes: alternate full-range and small-amplitude voices.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (k % 2 == 0) begin
                    snd_v[i*IN_W +: IN_W] = IN_W'($urandom);
                end else begin
                    tmp = int'($urandom_range(4000)) - 2000;
                    snd_v[i*IN_W +: IN_W] = tmp[IN_W-1:0];
                end
                gn_v[i*GAIN_W +: GAIN_W] = GAIN_W'($urandom);
            end
            mt_v = NUM_CH'($urandom);
            run_mix($sformatf("rnd%0d", k), snd_v, gn_v, mt_v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
